piso_tx: RTL and testbench
==========================

PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter N, default 8, word width in bits (legal range 2..32).
REQ-002 Parameter MSB_FIRST, default 0; 0 = LSB transmitted first, 1 = MSB transmitted first.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RESETN  input  1  reset, synchronous, active-low; sampled on the rising edge of CLK.
REQ-005 CE  input  1  clock enable; when 0 all internal state holds.
REQ-006 I  input  N  parallel word to serialize.
REQ-007 VALID  input  1  I holds a word to transmit.
REQ-008 READY  output  1  block accepts a word this cycle.
REQ-009 O  output  1  serial data, registered.
REQ-010 FRAME  output  1  registered; high in every cycle in which O carries a data bit.
REQ-011 LAST  output  1  registered; high in the cycle in which O carries bit N-1 of the word (the final bit sent).

Function
REQ-012 The block SHALL have two states: IDLE and SHIFT.
REQ-013 The block SHALL accept a word on the rising edge where VALID=1, READY=1 and CE=1; no other condition transfers a word.
REQ-014 READY SHALL be combinational: 1 in IDLE; 1 in SHIFT only when LAST=1; 0 otherwise; READY does not depend on CE.
REQ-015 On acceptance, the block SHALL load I into an N-bit shift register, set the bit counter to 0 and enter or stay in SHIFT.
REQ-016 Latency: the first bit of an accepted word SHALL appear on O in the cycle immediately after the accepting edge, with FRAME=1.
REQ-017 In SHIFT, each rising edge with CE=1 SHALL advance O to the next bit and increment the counter; counter width is ceil(log2(N)).
REQ-018 Bit order SHALL be I[0],I[1],...,I[N-1] when MSB_FIRST=0 and I[N-1],...,I[0] when MSB_FIRST=1.
REQ-019 Each word SHALL occupy exactly N CE-enabled cycles on O; with CE held at 1 that is N consecutive clock cycles.
REQ-020 When LAST=1 and a word is accepted at that edge, the next word's first bit SHALL follow with no gap; FRAME stays 1 and the counter wraps to 0.
REQ-021 When LAST=1, CE=1 and no word is accepted, the block SHALL enter IDLE at that edge.
REQ-022 In IDLE: O=0, FRAME=0, LAST=0.
REQ-023 When CE=0, O, FRAME, LAST, the state and the counter SHALL hold; each bit is stretched by the number of CE=0 cycles.
REQ-024 When VALID=1 while READY=0, the word SHALL not be sampled and SHALL not affect O; the sender holds I and VALID until acceptance.
REQ-025 I SHALL be sampled only at the accepting edge; changes to I during SHIFT SHALL not affect the word in flight.

Reset
REQ-026 When RESETN=0 at a rising edge, regardless of CE, the block SHALL enter IDLE, clear the counter and shift register, and drive O=0, FRAME=0, LAST=0 from the following cycle; READY=1.
REQ-027 A word in flight when reset is asserted SHALL be discarded with no further bits emitted; a word presented with VALID=1 on a reset edge SHALL not be accepted.
REQ-028 After RESETN returns to 1, the first edge with VALID=1 and CE=1 SHALL be accepted normally.

Verification
REQ-029 N=8, MSB_FIRST=0, CE=1, accept 0xA5 -> O over the next 8 cycles = 1,0,1,0,0,1,0,1; FRAME=1 for those 8 cycles; LAST=1 in the 8th only; then IDLE with O=0.
REQ-030 N=8, MSB_FIRST=1, accept 0x81 -> O = 1,0,0,0,0,0,0,1; READY=0 during cycles 1-7 and 1 in cycle 8.
REQ-031 Back-to-back: VALID held at 1 with 0xA5 then 0x3C -> 16 consecutive FRAME=1 cycles; O = 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0; LAST pulses in cycles 8 and 16.
REQ-032 CE pattern 1,0,1,0,... while sending 0xA5 -> each bit held for 2 cycles; FRAME=1 for 16 cycles; bit sequence same as REQ-029.
REQ-033 RESETN=0 during the 4th bit of 0xFF -> O=0, FRAME=0, READY=1 from the cycle after the reset edge; no further 1s appear on O.
REQ-034 VALID=1 with 0x00 while busy sending 0xFF -> O stays 1 for all 8 bits of 0xFF; 0x00 is accepted only at the LAST edge.

Source files
------------

// File: rtl/piso_tx.sv
// Parallel-in, serial-out transmitter: accepts an N-bit word through a VALID/READY
// handshake and emits it one bit per CE-enabled cycle with FRAME and LAST markers.
module piso_tx #(
    parameter int unsigned N         = 8,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic         clk_i,
    input  logic         resetn_i,
    input  logic         ce_i,
    input  logic [N-1:0] i_i,
    input  logic         valid_i,
    output logic         ready_o,
    output logic         o_o,
    output logic         frame_o,
    output logic         last_o
);

    localparam int unsigned CW = $clog2(N);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   word_ord;
    logic [N-1:0]   shreg_q, shreg_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           o_q, o_d;
    logic           frame_q, frame_d;
    logic           last_q, last_d;
    logic           accept;

    // Reorder the input so bit 0 is always the first bit on the wire; the
    // shifter then only ever shifts right regardless of MSB_FIRST.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_order
            if (MSB_FIRST) begin : g_msb
                assign word_ord[gi] = i_i[N-1-gi];
            end else begin : g_lsb
                assign word_ord[gi] = i_i[gi];
            end
        end
    endgenerate

    assign ready_o = (state_q == IDLE) || last_q;
    assign accept  = valid_i && ready_o && ce_i;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        o_d     = o_q;
        frame_d = frame_q;
        last_d  = last_q;
        if (ce_i) begin
            if (accept) begin
                // First bit goes straight to O; the remainder waits in the shifter.
                state_d = SHIFT;
                shreg_d = {1'b0, word_ord[N-1:1]};
                cnt_d   = '0;
                o_d     = word_ord[0];
                frame_d = 1'b1;
                last_d  = 1'b0;
            end else if (state_q == SHIFT) begin
                if (last_q) begin
                    state_d = IDLE;
                    shreg_d = '0;
                    cnt_d   = '0;
                    o_d     = 1'b0;
                    frame_d = 1'b0;
                    last_d  = 1'b0;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    o_d     = shreg_q[0];
                    shreg_d = {1'b0, shreg_q[N-1:1]};
                    last_d  = (cnt_q == CW'(N-2));
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            o_q     <= 1'b0;
            frame_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            o_q     <= o_d;
            frame_q <= frame_d;
            last_q  <= last_d;
        end
    end

    assign o_o     = o_q;
    assign frame_o = frame_q;
    assign last_o  = last_q;

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: LSB-first and MSB-first instances share stimulus; a bit-queue
// scoreboard predicts every cycle, plus a hand-derived vector table.
module tb_piso_tx;

    logic       clk = 1'b0;
    logic       tb_resetn = 1'b0;
    logic       tb_ce = 1'b0;
    logic       tb_valid = 1'b0;
    logic [7:0] tb_data = 8'h00;

    logic rdy_l, o_l, frame_l, last_l;
    logic rdy_m, o_m, frame_m, last_m;

    always #5 clk = ~clk;

    piso_tx #(.N(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk_i(clk), .resetn_i(tb_resetn), .ce_i(tb_ce), .i_i(tb_data),
        .valid_i(tb_valid), .ready_o(rdy_l), .o_o(o_l), .frame_o(frame_l), .last_o(last_l)
    );

    piso_tx #(.N(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk_i(clk), .resetn_i(tb_resetn), .ce_i(tb_ce), .i_i(tb_data),
        .valid_i(tb_valid), .ready_o(rdy_m), .o_o(o_m), .frame_o(frame_m), .last_o(last_m)
    );

    typedef struct packed {
        logic o_l;
        logic o_m;
        logic last;
    } sb_bit_t;

    typedef struct {
        logic       rstn;
        logic       ce;
        logic       valid;
        logic [7:0] data;
        logic       exp_o_l;
        logic       exp_o_m;
        logic       exp_frame;
        logic       exp_last;
        logic       exp_ready;
    } vec_t;

    sb_bit_t sbq[$];
    vec_t    tbl[$];

    logic m_frame = 1'b0, m_o_l = 1'b0, m_o_m = 1'b0, m_last = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got {rdy,frame,last,o}=%b, want %b at %0t", name, act, exp, $time);
    endtask

    // One clock: drive inputs, advance the scoreboard model, compare both DUTs.
    task automatic step(input logic rstn, input logic ce, input logic valid, input logic [7:0] data);
        logic    m_rdy;
        sb_bit_t e;
        @(negedge clk);
        tb_resetn = rstn;
        tb_ce     = ce;
        tb_valid  = valid;
        tb_data   = data;
        m_rdy = !m_frame || m_last;
        if (!rstn) begin
            sbq.delete();
            {m_frame, m_o_l, m_o_m, m_last} = 4'b0000;
        end else if (ce) begin
            if (valid && m_rdy) begin
                for (int k = 0; k < 8; k++)
                    sbq.push_back('{o_l: data[k], o_m: data[7-k], last: (k == 7)});
            end
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                m_frame = 1'b1;
                m_o_l   = e.o_l;
                m_o_m   = e.o_m;
                m_last  = e.last;
            end else begin
                {m_frame, m_o_l, m_o_m, m_last} = 4'b0000;
            end
        end
        @(posedge clk);
        #1;
        chk("sb_lsb", {rdy_l, frame_l, last_l, o_l}, {!m_frame || m_last, m_frame, m_last, m_o_l});
        chk("sb_msb", {rdy_m, frame_m, last_m, o_m}, {!m_frame || m_last, m_frame, m_last, m_o_m});
    endtask

    task automatic tv(input logic rstn, input logic ce, input logic valid, input logic [7:0] data,
                      input logic eol, input logic eom, input logic efr, input logic ela, input logic erd);
        tbl.push_back('{rstn, ce, valid, data, eol, eom, efr, ela, erd});
    endtask

    initial begin
        // Single 0xA5: wire order 1,0,1,0,0,1,0,1 in both bit orders.
        tv(1,1,1,8'hA5, 1,1,1,0,0);
        tv(1,1,0,8'h00, 0,0,1,0,0);
        tv(1,1,0,8'h00, 1,1,1,0,0);
        tv(1,1,0,8'h00, 0,0,1,0,0);
        tv(1,1,0,8'h00, 0,0,1,0,0);
        tv(1,1,0,8'h00, 1,1,1,0,0);
        tv(1,1,0,8'h00, 0,0,1,0,0);
        tv(1,1,0,8'h00, 1,1,1,1,1);
        tv(1,1,0,8'h00, 0,0,0,0,1);
        // Single 0x01: LSB-first leads with the 1, MSB-first ends with it.
        tv(1,1,1,8'h01, 1,0,1,0,0);
        for (int k = 0; k < 6; k++) tv(1,1,0,8'h00, 0,0,1,0,0);
        tv(1,1,0,8'h00, 0,1,1,1,1);
        tv(1,1,0,8'h00, 0,0,0,0,1);
        // Back-to-back 0xA5 then 0x3C with VALID held high.
        tv(1,1,1,8'hA5, 1,1,1,0,0);
        tv(1,1,1,8'h3C, 0,0,1,0,0);
        tv(1,1,1,8'h3C, 1,1,1,0,0);
        tv(1,1,1,8'h3C, 0,0,1,0,0);
        tv(1,1,1,8'h3C, 0,0,1,0,0);
        tv(1,1,1,8'h3C, 1,1,1,0,0);
        tv(1,1,1,8'h3C, 0,0,1,0,0);
        tv(1,1,1,8'h3C, 1,1,1,1,1);
        tv(1,1,1,8'h3C, 0,0,1,0,0);
        tv(1,1,0,8'h00, 0,0,1,0,0);
        tv(1,1,0,8'h00, 1,1,1,0,0);
        tv(1,1,0,8'h00, 1,1,1,0,0);
        tv(1,1,0,8'h00, 1,1,1,0,0);
        tv(1,1,0,8'h00, 1,1,1,0,0);
        tv(1,1,0,8'h00, 0,0,1,0,0);
        tv(1,1,0,8'h00, 0,0,1,1,1);
        tv(1,1,0,8'h00, 0,0,0,0,1);

        // Reset, with a word offered on a reset edge that must not be taken.
        step(0, 1, 0, 8'h00);
        step(0, 1, 1, 8'hFF);
        step(1, 1, 0, 8'h00);

        foreach (tbl[k]) begin
            step(tbl[k].rstn, tbl[k].ce, tbl[k].valid, tbl[k].data);
            chk($sformatf("tbl[%0d]_lsb", k), {rdy_l, frame_l, last_l, o_l},
                {tbl[k].exp_ready, tbl[k].exp_frame, tbl[k].exp_last, tbl[k].exp_o_l});
            chk($sformatf("tbl[%0d]_msb", k), {rdy_m, frame_m, last_m, o_m},
                {tbl[k].exp_ready, tbl[k].exp_frame, tbl[k].exp_last, tbl[k].exp_o_m});
        end

        // 0x81 alone: READY low for bits 1-7, high on bit 8.
        step(1, 1, 1, 8'h81);
        for (int k = 0; k < 8; k++) step(1, 1, 0, 8'h00);

        // CE toggling 1,0,... while sending 0xA5: each bit stretched.
        step(1, 1, 1, 8'hA5);
        for (int k = 0; k < 16; k++) step(1, k[0], 1'b0, 8'h00);

        // Reset on the 4th bit of 0xFF, then immediate reacceptance.
        step(1, 1, 1, 8'hFF);
        step(1, 1, 0, 8'h00);
        step(1, 1, 0, 8'h00);
        step(1, 1, 0, 8'h00);
        step(0, 1, 0, 8'h00);
        for (int k = 0; k < 4; k++) step(1, 1, 0, 8'h00);
        step(1, 1, 1, 8'hC3);
        for (int k = 0; k < 9; k++) step(1, 1, 0, 8'h00);

        // Reset while CE is low still takes effect.
        step(1, 1, 1, 8'h5A);
        step(1, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        step(1, 1, 0, 8'h00);

        // 0x00 offered while 0xFF is in flight; taken only at the LAST edge.
        step(1, 1, 1, 8'hFF);
        for (int k = 0; k < 8; k++) step(1, 1, 1, 8'h00);
        for (int k = 0; k < 8; k++) step(1, 1, 0, 8'h00);

        // Random traffic, including changing I while busy and rare resets.
        for (int k = 0; k < 400; k++)
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 1) != 0), 8'($urandom_range(0, 255)));
        for (int k = 0; k < 12; k++) step(1, 1, 0, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
